// File: rtl/vga_vram_reader_pkg.sv
//==============================================================================
// Package : vga_vram_reader_pkg
// Brief   : Shared timing constants, widths, colour codes and the cell-to-address
//           helper for the VGA video-RAM reader.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package vga_vram_reader_pkg;

    // 640x480@60 Hz timing, counted in pixel periods / lines
    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;

    localparam int c_CELL_W    = 20;
    localparam int c_CELL_H    = 15;

    localparam int c_ADDR_W    = 10;
    localparam int c_COLOR_W   = 3;

    typedef logic [c_COLOR_W-1:0] color_t;

    // bit2 = R, bit1 = G, bit0 = B
    localparam color_t c_BLACK   = 3'b000;
    localparam color_t c_BLUE    = 3'b001;
    localparam color_t c_GREEN   = 3'b010;
    localparam color_t c_CYAN    = 3'b011;
    localparam color_t c_RED     = 3'b100;
    localparam color_t c_MAGENTA = 3'b101;
    localparam color_t c_YELLOW  = 3'b110;
    localparam color_t c_WHITE   = 3'b111;

    function automatic logic [c_ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                      input logic [4:0] col);
        return {row, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_counter.sv
//==============================================================================
// Module : vga_sync_counter
// Brief  : Pixel enable, h/v counters, cell sub-counters, raw syncs and the
//          active flag; also exposes next-pixel cell coordinates for addressing.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module vga_sync_counter
    import vga_vram_reader_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK,
    parameter int CELL_W    = c_CELL_W,
    parameter int CELL_H    = c_CELL_H
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pix_en,
    output logic       o_origin,
    output logic       o_active,
    output logic       o_cell_edge,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic [4:0] o_nxt_col,
    output logic [4:0] o_nxt_row,
    output logic       o_nxt_active
);

    localparam int         c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [4:0] c_CW_LAST  = 5'(CELL_W - 1);
    localparam logic [3:0] c_CH_LAST  = 4'(CELL_H - 1);

    logic       r_pix_en;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [4:0] r_hsub;
    logic [3:0] r_vsub;
    logic [4:0] r_col;
    logic [4:0] r_row;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_nxt_h;
    logic [9:0] w_nxt_v;
    logic [4:0] w_nxt_hsub;
    logic [3:0] w_nxt_vsub;
    logic [4:0] w_nxt_col;
    logic [4:0] w_nxt_row;

    always_comb begin
        w_h_wrap   = (r_hcount == c_H_LAST);
        w_v_wrap   = (r_vcount == c_V_LAST);
        w_nxt_h    = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        w_nxt_v    = r_vcount;
        w_nxt_hsub = r_hsub + 5'd1;
        w_nxt_col  = r_col;
        w_nxt_vsub = r_vsub;
        w_nxt_row  = r_row;

        if (w_h_wrap) begin
            w_nxt_hsub = 5'd0;
            w_nxt_col  = 5'd0;
        end else if (r_hsub == c_CW_LAST) begin
            w_nxt_hsub = 5'd0;
            w_nxt_col  = r_col + 5'd1;
        end

        // Vertical cell tracking only moves on a line wrap
        if (w_h_wrap) begin
            if (w_v_wrap) begin
                w_nxt_v    = 10'd0;
                w_nxt_vsub = 4'd0;
                w_nxt_row  = 5'd0;
            end else begin
                w_nxt_v = r_vcount + 10'd1;
                if (r_vsub == c_CH_LAST) begin
                    w_nxt_vsub = 4'd0;
                    w_nxt_row  = r_row + 5'd1;
                end else begin
                    w_nxt_vsub = r_vsub + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_en <= 1'b0;
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsub   <= 5'd0;
            r_vsub   <= 4'd0;
            r_col    <= 5'd0;
            r_row    <= 5'd0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                r_hcount <= w_nxt_h;
                r_vcount <= w_nxt_v;
                r_hsub   <= w_nxt_hsub;
                r_vsub   <= w_nxt_vsub;
                r_col    <= w_nxt_col;
                r_row    <= w_nxt_row;
            end
        end
    end

    assign o_pix_en     = r_pix_en;
    assign o_origin     = (r_hcount == 10'd0) && (r_vcount == 10'd0);
    assign o_active     = (r_hcount < c_H_VIS) && (r_vcount < c_V_VIS);
    assign o_cell_edge  = (r_hsub == 5'd0) || (r_vsub == 4'd0);
    assign o_hsync_n    = !((r_hcount >= c_HS_FIRST) && (r_hcount <= c_HS_LAST));
    assign o_vsync_n    = !((r_vcount >= c_VS_FIRST) && (r_vcount <= c_VS_LAST));
    assign o_nxt_col    = w_nxt_col;
    assign o_nxt_row    = w_nxt_row;
    assign o_nxt_active = (w_nxt_h < c_H_VIS) && (w_nxt_v < c_V_VIS);

endmodule

`default_nettype wire

// File: rtl/vga_vram_reader.sv
//==============================================================================
// Module : vga_vram_reader
// Brief  : Reads the 32x32-cell video RAM and drives 640x480@60 VGA (3-bit RGB).
//          Optional macro VGA_GRID_OVERLAY_EN paints cell borders white.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module vga_vram_reader
    import vga_vram_reader_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK,
    parameter int CELL_W    = c_CELL_W,
    parameter int CELL_H    = c_CELL_H
) (
    input  logic                 Clock,
    input  logic                 Reset,
    output logic [c_ADDR_W-1:0]  oVRAM_Address,
    input  logic [c_COLOR_W-1:0] iVRAM_Color,
    output logic                 oVGA_Red,
    output logic                 oVGA_Green,
    output logic                 oVGA_Blue,
    output logic                 oVGA_HSync,
    output logic                 oVGA_VSync,
    output logic                 oFrameStart
);

`ifdef VGA_GRID_OVERLAY_EN
    localparam bit c_GRID_OVERLAY = 1'b1;
`else
    localparam bit c_GRID_OVERLAY = 1'b0;
`endif

    logic       w_pix_en;
    logic       w_origin;
    logic       w_active;
    logic       w_cell_edge;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic [4:0] w_nxt_col;
    logic [4:0] w_nxt_row;
    logic       w_nxt_active;
    color_t     w_pix;

    logic [c_ADDR_W-1:0] r_addr;
    color_t              r_rgb;
    logic [1:0]          r_hs_pipe;
    logic [1:0]          r_vs_pipe;
    logic                r_frame_start;

    vga_sync_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CELL_W    (CELL_W),
        .CELL_H    (CELL_H)
    ) u_sync (
        .clk          (Clock),
        .rst          (Reset),
        .o_pix_en     (w_pix_en),
        .o_origin     (w_origin),
        .o_active     (w_active),
        .o_cell_edge  (w_cell_edge),
        .o_hsync_n    (w_hsync_n),
        .o_vsync_n    (w_vsync_n),
        .o_nxt_col    (w_nxt_col),
        .o_nxt_row    (w_nxt_row),
        .o_nxt_active (w_nxt_active)
    );

    always_comb begin
        w_pix = iVRAM_Color;
        if (c_GRID_OVERLAY && w_cell_edge) begin
            w_pix = c_WHITE;
        end
    end

    // The address for the upcoming pixel is launched on the same enable edge
    // that advances the counters, so RAM data is ready by the next enable edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_addr        <= '0;
            r_rgb         <= c_BLACK;
            r_hs_pipe     <= 2'b11;
            r_vs_pipe     <= 2'b11;
            r_frame_start <= 1'b0;
        end else begin
            r_hs_pipe     <= {r_hs_pipe[0], w_hsync_n};
            r_vs_pipe     <= {r_vs_pipe[0], w_vsync_n};
            r_frame_start <= w_pix_en & w_origin;
            if (w_pix_en) begin
                if (w_nxt_active) begin
                    r_addr <= cell_addr(w_nxt_row, w_nxt_col);
                end
                r_rgb <= w_active ? w_pix : c_BLACK;
            end
        end
    end

    assign oVRAM_Address = r_addr;
    assign oVGA_Red      = r_rgb[2];
    assign oVGA_Green    = r_rgb[1];
    assign oVGA_Blue     = r_rgb[0];
    assign oVGA_HSync    = r_hs_pipe[1];
    assign oVGA_VSync    = r_vs_pipe[1];
    assign oFrameStart   = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_vram_reader.sv
//==============================================================================
// Module : tb_vga_vram_reader
// Brief  : Bench for vga_vram_reader: a reduced-geometry instance (full frames)
//          and a default 640x480 instance, both checked cycle by cycle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_vga_vram_reader;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int cw; int ch;
    } geo_t;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } out_t;

    localparam geo_t GA = '{hv:64, hf:4, hs:8, hb:4, vv:64, vf:3, vs:2, vb:3, cw:2, ch:2};
    localparam geo_t GB = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, cw:20, ch:15};
    localparam int   P1_END = 23041;

`ifdef VGA_GRID_OVERLAY_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mem [0:1023];

    logic [9:0] addr_a, addr_b;
    logic [2:0] col_a, col_b;
    logic       red_a, grn_a, blu_a, hs_a, vs_a, fs_a;
    logic       red_b, grn_b, blu_b, hs_b, vs_b, fs_b;

    int  t = 0;
    bit  armed = 1'b0;
    int  ea_a = 0, ea_b = 0;
    int  n_total = 0, n_bad = 0;
    bit  phase1 = 1'b0;
    int  fs_cnt_a = 0, vs_low_a = 0;
    int  fall0 = -1, rise0 = -1, fall1 = -1;
    logic hs_prev_b = 1'b1;

    always #10 clk = ~clk;

    vga_vram_reader #(
        .H_VISIBLE (GA.hv), .H_FRONT (GA.hf), .H_SYNC (GA.hs), .H_BACK (GA.hb),
        .V_VISIBLE (GA.vv), .V_FRONT (GA.vf), .V_SYNC (GA.vs), .V_BACK (GA.vb),
        .CELL_W    (GA.cw), .CELL_H  (GA.ch)
    ) dut_a (
        .Clock (clk), .Reset (rst), .oVRAM_Address (addr_a), .iVRAM_Color (col_a),
        .oVGA_Red (red_a), .oVGA_Green (grn_a), .oVGA_Blue (blu_a),
        .oVGA_HSync (hs_a), .oVGA_VSync (vs_a), .oFrameStart (fs_a)
    );

    vga_vram_reader dut_b (
        .Clock (clk), .Reset (rst), .oVRAM_Address (addr_b), .iVRAM_Color (col_b),
        .oVGA_Red (red_b), .oVGA_Green (grn_b), .oVGA_Blue (blu_b),
        .oVGA_HSync (hs_b), .oVGA_VSync (vs_b), .oFrameStart (fs_b)
    );

    // Video RAM with one clock of read latency
    always @(posedge clk) begin
        col_a <= mem[addr_a];
        col_b <= mem[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic int cell_of(geo_t g, int x, int y);
        return ((y / g.ch) % 32) * 32 + ((x / g.cw) % 32);
    endfunction

    // Address the DUT should present while pixel t/2 is the current pixel;
    // -1 means that pixel is blanked and the previous address is held.
    function automatic int model_addr(geo_t g, int tc);
        int ht, vt, q, x, y;
        ht = g.hv + g.hf + g.hs + g.hb;
        vt = g.vv + g.vf + g.vs + g.vb;
        q  = (tc / 2) % (ht * vt);
        x  = q % ht;
        y  = q / ht;
        if (x < g.hv && y < g.vv) return cell_of(g, x, y);
        return -1;
    endfunction

    // Outputs trail the pixel position by two clocks
    function automatic out_t model_out(geo_t g, int tc);
        out_t o;
        int ht, vt, p, x, y;
        ht    = g.hv + g.hf + g.hs + g.hb;
        vt    = g.vv + g.vf + g.vs + g.vb;
        o.rgb = 3'b000;
        o.hs  = 1'b1;
        o.vs  = 1'b1;
        o.fs  = 1'b0;
        if (tc >= 2) begin
            p    = ((tc - 2) / 2) % (ht * vt);
            x    = p % ht;
            y    = p / ht;
            o.fs = (p == 0) && ((tc % 2) == 0);
            o.hs = !(x >= g.hv + g.hf && x < g.hv + g.hf + g.hs);
            o.vs = !(y >= g.vv + g.vf && y < g.vv + g.vf + g.vs);
            if (x < g.hv && y < g.vv) begin
                if (OVL && ((x % g.cw) == 0 || (y % g.ch) == 0)) o.rgb = 3'b111;
                else o.rgb = mem[cell_of(g, x, y)];
            end
        end
        return o;
    endfunction

    always @(posedge clk) begin
        int na, nb;
        if (rst) begin
            t     = 0;
            armed = 1'b1;
            ea_a  = 0;
            ea_b  = 0;
        end else if (armed) begin
            t  = t + 1;
            na = model_addr(GA, t);
            nb = model_addr(GB, t);
            if (na >= 0) ea_a = na;
            if (nb >= 0) ea_b = nb;
        end
    end

    always @(negedge clk) begin
        out_t oa, ob;
        if (armed) begin
            oa = model_out(GA, t);
            ob = model_out(GB, t);
            chk("a_rgb",   32'({red_a, grn_a, blu_a}), 32'(oa.rgb));
            chk("a_hsync", 32'(hs_a), 32'(oa.hs));
            chk("a_vsync", 32'(vs_a), 32'(oa.vs));
            chk("a_fstart", 32'(fs_a), 32'(oa.fs));
            chk("a_addr",  32'(addr_a), 32'(ea_a));
            chk("b_rgb",   32'({red_b, grn_b, blu_b}), 32'(ob.rgb));
            chk("b_hsync", 32'(hs_b), 32'(ob.hs));
            chk("b_vsync", 32'(vs_b), 32'(ob.vs));
            chk("b_fstart", 32'(fs_b), 32'(ob.fs));
            chk("b_addr",  32'(addr_b), 32'(ea_b));
        end
    end

    always @(negedge clk) begin
        if (armed && phase1 && !rst && t <= P1_END) begin
            if (fs_a) fs_cnt_a++;
            if (!vs_a) vs_low_a++;
            if (hs_prev_b && !hs_b) begin
                if (fall0 < 0) fall0 = t;
                else if (fall1 < 0) fall1 = t;
            end
            if (!hs_prev_b && hs_b && rise0 < 0) rise0 = t;
            hs_prev_b = hs_b;
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 3'($urandom);
        mem[0]    = 3'b010;
        mem[1]    = 3'b100;
        mem[1023] = 3'b001;
    endtask

    task automatic wait_t(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_t", 32'(t), 32'(target));
    endtask

    task automatic reset_pulse(input int n, input bit newmem);
        rst = 1'b1;
        @(negedge clk);
        if (newmem) fill_mem();
        repeat (n - 1) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        fill_mem();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst    = 1'b0;
        phase1 = 1'b1;
        wait_t(P1_END + 1);
        phase1 = 1'b0;

        chk("a_fstart_count", 32'(fs_cnt_a), 32'd2);
        chk("a_vsync_low_clocks", 32'(vs_low_a), 32'd640);
        chk("b_hsync_fall", 32'(fall0), 32'd1314);
        chk("b_hsync_width", 32'(rise0 - fall0), 32'd192);
        chk("b_line_period", 32'(fall1 - fall0), 32'd1600);

        // Reset while the reduced instance is inside its HSync pulse
        reset_pulse(1, 1'b0);
        wait_t(2 * (10 * 80 + 70) + 5);
        reset_pulse(2, 1'b1);

        for (int k = 0; k < 4; k++) begin
            wait_t(int'($urandom_range(300, 6000)));
            reset_pulse(int'($urandom_range(1, 3)), 1'b1);
        end
        wait_t(12000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
